// File: rtl/byte_tx_pkg.sv
// Shared definitions for the byte_tx serial transmitter.
// Contents: FSM state encoding, idle line level, data/counter widths.
package byte_tx_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/byte_tx_if.sv
// Data/line bundle between the upstream controller, byte_tx and the serial line.
// Signals: din (byte to send), txd (serial line), busy (frame on line),
// done (end-of-frame pulse).
// master: drives din, observes line/status. slave: the transmitter.
interface byte_tx_if;
    import byte_tx_pkg::*;

    logic [BYTE_W-1:0] din;
    logic              txd;
    logic              busy;
    logic              done;

    modport master (output din, input txd, input busy, input done);
    modport slave  (input din, output txd, output busy, output done);
endinterface

// File: rtl/byte_tx_baud_tick.sv
// baud_tick: DIV-cycle counter counting 0..DIV-1 with synchronous clear.
// Ports: clk, rst_n (async active-low), clear (restart at 0 next cycle),
// tick (count == DIV-1, registered), near (count == DIV-2, registered).
module baud_tick #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic near
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at DIV-1 or restart on clear
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == CW'(DIV - 1))) begin
            cnt_d = '0;
        end
    end

    // Flags are registered against the next count so they line up with cnt_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
            near  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == CW'(DIV - 1));
            near  <= (cnt_d == CW'(DIV - 2));
        end
    end

endmodule

// File: rtl/byte_tx.sv
// byte_tx: sends a byte as an 8N1 frame on txd whenever din changes.
// Ports: clk, rst_n (async active-low), bus (byte_tx_if.slave: din, txd,
// busy, done). DIV = CLK_FREQ/BAUD clock cycles per bit, DIV >= 2.
// Only the latest changed byte is held for sending (one-entry hold).
// Build option: define BYTE_TX_PARITY_EN for 8E1 (even parity bit).
module byte_tx
    import byte_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    byte_tx_if.slave   bus
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;

    state_e                 state_q, state_d;
    logic [BYTE_W-1:0]      din_q;
    logic                   pend_q, pend_d;
    logic [BYTE_W-1:0]      pend_data_q, pend_data_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   clear_c;
    logic                   tick;
    logic                   near;
`ifdef BYTE_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    // Bit-period timer, restarted on every state entry and while idle
    baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_c),
        .tick  (tick),
        .near  (near)
    );

    // State register and registered line/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            din_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            txd_q       <= LINE_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BYTE_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            din_q       <= bus.din;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef BYTE_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next-state, hold register and output decode
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef BYTE_TX_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = START;
                    shift_d = pend_data_q;
                    pend_d  = 1'b0;
`ifdef BYTE_TX_PARITY_EN
                    par_d   = ^pend_data_q;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
`ifdef BYTE_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef BYTE_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new byte overrides the idle-load clear on the same edge
        if (bus.din != din_q) begin
            pend_d      = 1'b1;
            pend_data_d = bus.din;
        end

        clear_c = (state_d != state_q) || (state_q == IDLE);

        // Line level follows the state being entered, so txd is a clean flop
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef BYTE_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = LINE_IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // near in STOP means the next cycle is the last one of the frame
        done_d = (state_q == STOP) && near;
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_byte_tx.sv
// Directed self-checking bench for byte_tx at CLK_FREQ=8, BAUD=1 (DIV=8).
module tb_byte_tx;

`ifdef BYTE_TX_PARITY_EN
    localparam int FRAME = 88;
`else
    localparam int FRAME = 80;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         found;
        int         gap;
        int         bad_start;
        int         bad_bits;
        int         bad_stop;
        int         done_cnt;
        int         done_at;
        int         busy_low;
    } rx_t;

    byte_tx_if bus ();

    byte_tx #(.CLK_FREQ(8), .BAUD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_watch(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
    endtask

    // Waits (bounded) for a start bit, then samples one full frame, one sample per cycle
    task automatic rx_frame(output rx_t r);
        logic s [88];
        r = '{data: 8'h00, par: 1'b0, found: 1'b0, gap: 0, bad_start: 0,
              bad_bits: 0, bad_stop: 0, done_cnt: 0, done_at: 0, busy_low: 0};
        for (int w = 0; w < 400; w++) begin
            if (bus.txd === 1'b0) begin
                r.found = 1'b1;
                break;
            end
            r.gap++;
            @(negedge clk);
        end
        if (!r.found) return;
        for (int c = 1; c <= FRAME; c++) begin
            s[c-1] = bus.txd;
            if (bus.done === 1'b1) begin
                r.done_cnt++;
                r.done_at = c;
            end
            if (bus.busy !== 1'b1) r.busy_low++;
            if (c < FRAME) @(negedge clk);
        end
        for (int c = 0; c < 8; c++) if (s[c] !== 1'b0) r.bad_start++;
        for (int i = 0; i < 8; i++) begin
            r.data[i] = s[8 + 8*i + 3];
            for (int j = 0; j < 8; j++) if (s[8 + 8*i + j] !== r.data[i]) r.bad_bits++;
        end
`ifdef BYTE_TX_PARITY_EN
        r.par = s[72 + 3];
        for (int j = 0; j < 8; j++) if (s[72 + j] !== r.par) r.bad_bits++;
`endif
        for (int c = FRAME - 8; c < FRAME; c++) if (s[c] !== 1'b1) r.bad_stop++;
    endtask

    task automatic check_frame(input string tag, input rx_t r, input logic [7:0] exp_data,
                               input logic exp_par, input int exp_gap);
        check({tag, ".found"},     32'(r.found), 32'd1);
        check({tag, ".data"},      32'(r.data), 32'(exp_data));
        check({tag, ".gap"},       32'(r.gap), 32'(exp_gap));
        check({tag, ".start"},     32'(r.bad_start), 32'd0);
        check({tag, ".bits"},      32'(r.bad_bits), 32'd0);
        check({tag, ".stop"},      32'(r.bad_stop), 32'd0);
        check({tag, ".done_cnt"},  32'(r.done_cnt), 32'd1);
        check({tag, ".done_at"},   32'(r.done_at), 32'(FRAME));
        check({tag, ".busy"},      32'(r.busy_low), 32'd0);
`ifdef BYTE_TX_PARITY_EN
        check({tag, ".parity"},    32'(r.par), 32'(exp_par));
`else
        if (exp_par !== r.par && 1'b0) check({tag, ".parity"}, 32'(r.par), 32'(exp_par));
`endif
    endtask

    initial begin
        rx_t f1, f2;
        int  bad;
        bit  seen;

        rst_n   = 1'b0;
        bus.din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.txd",  32'(bus.txd),  32'd1);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        // Unchanged din after reset: line stays idle
        idle_watch(200, bad);
        check("idle_after_reset", 32'(bad), 32'd0);

        // 00 -> 01: pend at edge N, start bit from edge N+1; mid-frame 03 then 07
        bus.din = 8'h01;
        @(negedge clk);
        check("lat.n.txd",   32'(bus.txd),  32'd1);
        check("lat.n.busy",  32'(bus.busy), 32'd0);
        @(negedge clk);
        check("lat.n1.txd",  32'(bus.txd),  32'd0);
        check("lat.n1.busy", 32'(bus.busy), 32'd1);
        fork
            rx_frame(f1);
            begin
                repeat (20) @(negedge clk);
                bus.din = 8'h03;
                repeat (20) @(negedge clk);
                bus.din = 8'h07;
            end
        join
        check_frame("f01", f1, 8'h01, 1'b1, 0);
        @(negedge clk);
        check("gap.txd",  32'(bus.txd),  32'd1);
        check("gap.busy", 32'(bus.busy), 32'd0);
        rx_frame(f2);
        check_frame("f07", f2, 8'h07, 1'b1, 1);
        idle_watch(200, bad);
        check("no_03_frame", 32'(bad), 32'd0);

        // Change lands on the same edge as the idle load: both bytes go out
        bus.din = 8'h11;
        @(negedge clk);
        bus.din = 8'h20;
        rx_frame(f1);
        check_frame("f11", f1, 8'h11, 1'b0, 1);
        @(negedge clk);
        rx_frame(f2);
        check_frame("f20", f2, 8'h20, 1'b1, 1);

        // Reset during data bit 4 with another byte pending
        bus.din = 8'h4A;
        seen = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (bus.txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort.start_seen", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        bus.din = 8'h33;
        repeat (23) @(negedge clk);
        check("abort.bit4",      32'(bus.txd),  32'd0);
        check("abort.busy_pre",  32'(bus.busy), 32'd1);
        #2;
        rst_n   = 1'b0;
        bus.din = 8'h00;
        #1;
        check("abort.txd",  32'(bus.txd),  32'd1);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_watch(200, bad);
        check("abort.no_frame", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
